sdpb_stream_reader: RTL and testbench

Read-side engine for the double-buffer SDPB. It takes a start command with a base address and word count and issues sequential reads on the SDPB read port (ceb/oce/adb/dout). It absorbs the RAM's fixed read latency and presents the words as a valid/ready stream toward the matrix output path. Write-side and read-side run independently; this block owns only port B and sits between the SDPB and the matrix serializer.

---
 rtl/sdpb_stream_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_sdpb_stream_reader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : sdpb_stream_reader
// Purpose  : Read-side engine for the double-buffer SDPB. Accepts a
//            (base_addr, length) command, issues sequential reads on SDPB
//            port B, absorbs the fixed RAM read latency and presents the
//            words as a valid/ready stream.
// Ports    : clk, resetn            - clock (also SDPB clkb), async low reset
//            start/base_addr/length - command pulse and its arguments
//            busy, done             - command status (done is a 1-cycle pulse)
//            ram_ce/ram_oce/ram_adb - SDPB ceb / oce / adb
//            ram_dout               - SDPB dout
//            m_data/m_valid/m_ready - output stream
// Revision : 1.0 - initial release
// ============================================================================
module sdpb_stream_reader #(
    parameter int ADDRESS_DEPTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int READ_LATENCY  = 2,   // 1 = bypass, 2 = output register
    parameter int FIFO_DEPTH    = 4,   // >= READ_LATENCY+2 for full rate
    localparam int AW           = $clog2(ADDRESS_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ce,
    output logic                  ram_oce,
    output logic [AW-1:0]         ram_adb,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);             // FIFO count width
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = CW + 1;                              // occupancy width

    localparam logic [OW-1:0] DEPTH_OCC  = OW'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(ADDRESS_DEPTH - 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   ONE_WORD   = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q,      state_d;
    logic [AW-1:0]           addr_q,       addr_d;
    logic [AW:0]             remaining_q,  remaining_d;
    logic [READ_LATENCY-1:0] pipe_q,       pipe_d;
    logic [CW-1:0]           fifo_count_q, fifo_count_d;
    logic [PW-1:0]           wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q,     rd_ptr_d;
    logic                    busy_q,       busy_d;
    logic                    done_q,       done_d;

    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

    logic [CW-1:0]           inflight;
    logic [OW-1:0]           occupancy;
    logic                    issue;
    logic                    push;
    logic                    pop;

    // ------------------------------------------------------------------
    // Flow control. Occupancy counts words already in the FIFO plus reads
    // still travelling through the RAM, so every issued read is guaranteed
    // a FIFO slot when it lands. Only registered values are used, so a pop
    // frees its slot for issue one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
    end

    assign occupancy = {1'b0, fifo_count_q} + {1'b0, inflight};
    assign issue     = (state_q == ST_READ) && (occupancy < DEPTH_OCC);
    assign push      = pipe_q[READ_LATENCY-1];
    assign m_valid   = (fifo_count_q != '0);
    assign pop       = m_valid & m_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        fifo_count_d = fifo_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        // Latency pipe: one valid bit per outstanding RAM read.
        pipe_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d      = base_addr;
                        remaining_d = length;
                        state_d     = ST_READ;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
                    remaining_d = remaining_q - ONE_WORD;
                    if (remaining_q == ONE_WORD) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Looking at the post-pop count lets done appear in the
                // cycle right after the final handshake.
                if ((pipe_q == '0) && (fifo_count_d == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            pipe_q       <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            pipe_q       <= pipe_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // FIFO storage needs no reset: nothing is visible unless the count is
    // non-zero, and the read mux below forces zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= ram_dout;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy    = busy_q;
    assign done    = done_q;
    assign ram_ce  = issue;
    assign ram_adb = addr_q;
    assign m_data  = m_valid ? fifo_mem[rd_ptr_q] : '0;

    // In output-register mode the RAM's dout register must load on the
    // cycle after the address was sampled.
    generate
        if (READ_LATENCY == 2) begin : g_oce_reg
            assign ram_oce = pipe_q[0];
        end else begin : g_oce_bypass
            assign ram_oce = 1'b0;
        end
    endgenerate

    // The occupancy credit makes overflow impossible; a push into a full
    // FIFO without a simultaneous pop indicates a broken credit scheme.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!resetn)
        !(push && !pop && (fifo_count_q == DEPTH_CNT))
    );

endmodule
`default_nettype wire

// File: tb/tb_sdpb_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdpb_stream_reader
// Purpose  : Self-checking bench for sdpb_stream_reader with a behavioural
//            SDPB read port (output-register mode). Expected addresses and
//            words are queued when a command is driven and retired by a
//            monitor as the DUT issues reads and completes handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdpb_stream_reader;

    localparam int ADDRESS_DEPTH = 16;
    localparam int DATA_WIDTH    = 16;
    localparam int READ_LATENCY  = 2;
    localparam int FIFO_DEPTH    = 4;
    localparam int AW            = 4;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [AW:0]           length;
    logic                  busy;
    logic                  done;
    logic                  ram_ce;
    logic                  ram_oce;
    logic [AW-1:0]         ram_adb;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    always #5 clk = ~clk;

    sdpb_stream_reader #(
        .ADDRESS_DEPTH (ADDRESS_DEPTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_adb   (ram_adb),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    // Behavioural SDPB read port: 32-bit words DEADBEEF^i seen as 16-bit
    // halves, low half at the even address. Address register + output reg.
    logic [15:0] ram_mem [16];
    logic [15:0] ram_s1;
    logic [15:0] ram_q;
    assign ram_dout = ram_q;

    always @(posedge clk) begin
        if (ram_ce)  ram_s1 <= ram_mem[ram_adb];
        if (ram_oce) ram_q  <= ram_s1;
    end

    // Scoreboard state
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_data [$];
    logic [3:0]  exp_addr [$];
    bit          stalled;
    logic [15:0] stall_data;
    bit          prev_ce;
    int          outstanding;
    int          hs_count;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [3:0] a);
        return a[0] ? 16'hDEAD : (16'hBEEF ^ {13'd0, a[3:1]});
    endfunction

    task automatic queue_cmd(input logic [3:0] base, input int len);
        logic [3:0] a;
        for (int k = 0; k < len; k++) begin
            a = base + 4'(k);
            exp_addr.push_back(a);
            exp_data.push_back(exp_word(a));
        end
    endtask

    // Called at posedge+1; returns at E0+1 (first cycle after start sampled).
    task automatic issue_start(input logic [3:0] base, input logic [4:0] len);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, done, 1);
    endtask

    // Monitor: retire issued addresses and handshaken words, check stall
    // stability and the outstanding-word bound.
    always @(negedge clk) begin
        if (!resetn) begin
            stalled     = 1'b0;
            prev_ce     = 1'b0;
            outstanding = 0;
        end else begin
            if (ram_oce || prev_ce) chk("ram_oce", ram_oce, prev_ce);
            if (ram_ce) begin
                if (exp_addr.size() == 0) chk("unexpected_issue", 1, 0);
                else chk("ram_adb", ram_adb, exp_addr.pop_front());
                outstanding++;
                chk("outstanding_bound", (outstanding <= FIFO_DEPTH), 1);
            end
            if (stalled) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready) begin
                if (exp_data.size() == 0) chk("extra_word", 1, 0);
                else chk("m_data", m_data, exp_data.pop_front());
                outstanding--;
                hs_count++;
            end
            stalled    = m_valid && !m_ready;
            stall_data = m_data;
            prev_ce    = ram_ce;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        for (int i = 0; i < 8; i++) begin
            {ram_mem[2*i+1], ram_mem[2*i]} = 32'hDEADBEEF ^ i;
        end
        ram_s1    = '0;
        ram_q     = '0;
        resetn    = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        hs_count  = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    busy,    0);
        chk("rst_done",    done,    0);
        chk("rst_ram_ce",  ram_ce,  0);
        chk("rst_ram_oce", ram_oce, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_ram_adb", ram_adb, 0);
        chk("rst_m_data",  m_data,  0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full read, back-to-back
        m_ready = 1'b1;
        queue_cmd(4'd0, 16);
        issue_start(4'd0, 5'd16);
        chk("t1_first_ce", ram_ce, 1);
        chk("t1_busy", busy, 1);
        lat = 0;
        while (!m_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t1_first_valid_latency", lat, READ_LATENCY + 1);
        for (int i = 0; i < 16; i++) begin
            chk("t1_stream_valid", m_valid, 1);
            @(posedge clk); #1;
        end
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_all_words", exp_data.size(), 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);

        // Wrap-around
        queue_cmd(4'd14, 4);
        issue_start(4'd14, 5'd4);
        wait_done(40, "t2_done");
        chk("t2_addr_left", exp_addr.size(), 0);
        chk("t2_data_left", exp_data.size(), 0);
        @(posedge clk); #1;

        // Backpressure
        m_ready = 1'b0;
        queue_cmd(4'd0, 16);
        issue_start(4'd0, 5'd16);
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_first_valid", m_valid, 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        n = 0;
        while (!done && n < 200) begin
            m_ready = ~m_ready;
            @(posedge clk); #1;
            n++;
        end
        chk("t3_done", done, 1);
        chk("t3_data_left", exp_data.size(), 0);
        chk("t3_addr_left", exp_addr.size(), 0);
        m_ready = 1'b1;
        @(posedge clk); #1;

        // Zero length
        issue_start(4'd3, 5'd0);
        chk("t4_zero_done", done, 1);
        chk("t4_zero_busy", busy, 0);
        chk("t4_zero_ce", ram_ce, 0);
        @(posedge clk); #1;
        chk("t4_zero_done_pulse", done, 0);

        // Start while busy and start during DONE are both ignored
        queue_cmd(4'd4, 3);
        issue_start(4'd4, 5'd3);
        @(posedge clk); #1;
        chk("t4_busy", busy, 1);
        start = 1'b1; base_addr = 4'd8; length = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, "t4_done");
        start = 1'b1; base_addr = 4'd10; length = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_start_in_done_busy", busy, 0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("t4_no_extra_valid", m_valid, 0);
        chk("t4_data_left", exp_data.size(), 0);
        chk("t4_addr_left", exp_addr.size(), 0);

        // Asynchronous reset mid-command
        hs_count = 0;
        queue_cmd(4'd0, 16);
        issue_start(4'd0, 5'd16);
        n = 0;
        while (hs_count < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_five_handshakes", hs_count, 5);
        #1;
        resetn = 1'b0;
        #1;
        chk("t5_rst_busy",    busy,    0);
        chk("t5_rst_done",    done,    0);
        chk("t5_rst_ram_ce",  ram_ce,  0);
        chk("t5_rst_ram_oce", ram_oce, 0);
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_ram_adb", ram_adb, 0);
        chk("t5_rst_m_data",  m_data,  0);
        exp_data.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        hs_count = 0;
        queue_cmd(4'd2, 2);
        issue_start(4'd2, 5'd2);
        wait_done(40, "t5_done");
        chk("t5_words", hs_count, 2);
        chk("t5_data_left", exp_data.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
